// File: rtl/alu_ctrl_exec_seq.sv
// alu_ctrl_exec_seq
//   Decodes ALUOp plus the R-format opcode (instruction[31:21]) into a 4-bit
//   ALU control code and executes the operation on operands captured at issue.
//   Single-cycle ops complete in one cycle. MUL (optional) is an iterative
//   shift-add sequencer taking WIDTH cycles. Valid/ready handshake on both the
//   issue side and the result side.
//
//   Build option: define ALU_MUL_EN to build the MUL state and sequencer.
//   Without it the MUL opcode decodes as illegal.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     issue request
//   in_ready     block can accept an issue this cycle
//   alu_op       ALUOp from main control
//   instruction  instruction word, opcode = instruction[31:21]
//   op_a, op_b   operands (WIDTH bits)
//   out_valid    result valid
//   out_ready    consumer accepts result
//   code         decoded ALU control code of the held result
//   result       ALU result (WIDTH bits)
//   zero         result == 0
//   illegal      opcode not decodable
//
// States
//   IDLE | waiting for an issue, in_ready=1
//   MUL  | shift-add multiply in progress, in_ready=0
//   DONE | result held, out_valid=1, in_ready follows out_ready
module alu_ctrl_exec_seq #(
  parameter int WIDTH = 64,
  parameter int OPC_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       code,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_ORR  = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_PASS = 4'b0111;
  localparam logic [3:0] C_ILL  = 4'b1111;

  localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(11'b10001011000);
  localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(11'b11001011000);
  localparam logic [OPC_W-1:0] OPC_AND = OPC_W'(11'b10001010000);
  localparam logic [OPC_W-1:0] OPC_ORR = OPC_W'(11'b10101010000);
`ifdef ALU_MUL_EN
  localparam logic [3:0]       C_MUL   = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_MUL = OPC_W'(11'b10011011000);
  localparam int               CNT_W   = $clog2(WIDTH);
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_nx;
  logic [OPC_W-1:0] opcode;
  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             dec_mul;
  logic [WIDTH-1:0] alu_res;
  logic             issue;
  logic             mul_last;

  logic [WIDTH-1:0] result_q;
  logic [3:0]       code_q;
  logic             zero_q;
  logic             illegal_q;

  // Only the opcode field of the instruction is decoded here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[31-OPC_W:0];

  assign opcode = instruction[31 -: OPC_W];

  // alu_op[0] set means CBZ pass-through and wins over the R-format decode.
  always_comb begin
    dec_code = C_ILL;
    if (alu_op[0]) begin
      dec_code = C_PASS;
    end else if (!alu_op[1]) begin
      dec_code = C_ADD;
    end else begin
      case (opcode)
        OPC_ADD: dec_code = C_ADD;
        OPC_SUB: dec_code = C_SUB;
        OPC_AND: dec_code = C_AND;
        OPC_ORR: dec_code = C_ORR;
`ifdef ALU_MUL_EN
        OPC_MUL: dec_code = C_MUL;
`endif
        default: dec_code = C_ILL;
      endcase
    end
  end

  assign dec_illegal = (dec_code == C_ILL);
`ifdef ALU_MUL_EN
  assign dec_mul = (dec_code == C_MUL);
`else
  assign dec_mul = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (dec_code)
      C_ADD:   alu_res = op_a + op_b;
      C_SUB:   alu_res = op_a - op_b;
      C_AND:   alu_res = op_a & op_b;
      C_ORR:   alu_res = op_a | op_b;
      C_PASS:  alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign issue     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: state_nx = S_IDLE;
`ifdef ALU_MUL_EN
      S_MUL:  if (mul_last) state_nx = S_DONE;
`endif
      S_DONE: if (out_ready && !in_valid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // An issue from IDLE or a back-to-back issue from DONE overrides the above.
    if (issue) state_nx = dec_mul ? state_t'(2'd1) : S_DONE;
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_nx;
  logic [CNT_W-1:0] cnt_q;

  assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
`else
  assign mul_last = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      code_q    <= 4'b0000;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else if (issue) begin
      code_q    <= dec_code;
      illegal_q <= dec_illegal;
`ifdef ALU_MUL_EN
      if (dec_mul) begin
        mcand_q  <= op_a;
        mplier_q <= op_b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
      end
`else
      result_q  <= alu_res;
      zero_q    <= (alu_res == '0);
`endif
    end
`ifdef ALU_MUL_EN
    else if (state_q == S_MUL) begin
      acc_q    <= acc_nx;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      // The last step writes the product straight into the result register.
      if (mul_last) begin
        result_q <= acc_nx;
        zero_q   <= (acc_nx == '0);
      end
    end
`endif
  end

  assign result  = result_q;
  assign code    = code_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_exec_seq.sv
module tb_alu_ctrl_exec_seq;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    alu_op;
  logic [31:0]   instruction;
  logic [W-1:0]  op_a, op_b;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    code;
  logic [W-1:0]  result;
  logic          zero;
  logic          illegal;

  int nchk = 0;
  int nerr = 0;

  alu_ctrl_exec_seq #(.WIDTH(W), .OPC_W(11)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .instruction(instruction),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .code(code), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] O_ADD = 11'b10001011000;
  localparam logic [10:0] O_SUB = 11'b11001011000;
  localparam logic [10:0] O_AND = 11'b10001010000;
  localparam logic [10:0] O_ORR = 11'b10101010000;
  localparam logic [10:0] O_MUL = 11'b10011011000;
  localparam logic [10:0] O_BAD = 11'b11111111111;

  typedef struct {
    logic [1:0]   op;
    logic [10:0]  opc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   e_code;
    logic [W-1:0] e_res;
    logic         e_zero;
    logic         e_ill;
  } vec_t;

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] res;
    logic         ill;
  } exp_t;

  // Reference: the decode table and plain arithmetic on the operands.
  function automatic exp_t model(input logic [1:0] op, input logic [10:0] opc,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.code = 4'hF; e.res = '0; e.ill = 1'b0;
    if (op == 2'b01 || op == 2'b11) begin
      e.code = 4'h7; e.res = b;
    end else if (op == 2'b00) begin
      e.code = 4'h2; e.res = a + b;
    end else if (opc == O_ADD) begin
      e.code = 4'h2; e.res = a + b;
    end else if (opc == O_SUB) begin
      e.code = 4'h6; e.res = a - b;
    end else if (opc == O_AND) begin
      e.code = 4'h0; e.res = a & b;
    end else if (opc == O_ORR) begin
      e.code = 4'h1; e.res = a | b;
`ifdef ALU_MUL_EN
    end else if (opc == O_MUL) begin
      e.code = 4'h8; e.res = a * b;
`endif
    end
    e.ill = (e.code == 4'hF);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [10:0] opc,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid    = 1'b1;
    alu_op      = op;
    instruction = {opc, 21'($urandom)};
    op_a        = a;
    op_b        = b;
  endtask

  vec_t vecs[9];
  logic [10:0] opcs[6];

  initial begin
    vecs[0] = '{2'b10, O_SUB, 64'd5, 64'd5, 4'h6, 64'd0, 1'b1, 1'b0};
    vecs[1] = '{2'b01, O_ADD, 64'd9, 64'd0, 4'h7, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{2'b10, O_BAD, 64'd9, 64'd4, 4'hF, 64'd0, 1'b1, 1'b1};
    vecs[3] = '{2'b00, O_BAD, 64'd100, 64'd23, 4'h2, 64'd123, 1'b0, 1'b0};
    vecs[4] = '{2'b11, O_SUB, 64'd1, 64'h55, 4'h7, 64'h55, 1'b0, 1'b0};
    vecs[5] = '{2'b10, O_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h2, 64'd0, 1'b1, 1'b0};
    vecs[6] = '{2'b10, O_SUB, 64'd3, 64'd5, 4'h6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[7] = '{2'b10, O_AND, 64'hF0F0, 64'hFF00, 4'h0, 64'hF000, 1'b0, 1'b0};
`ifdef ALU_MUL_EN
    vecs[8] = '{2'b10, O_ORR, 64'hA0, 64'h05, 4'h1, 64'hA5, 1'b0, 1'b0};
`else
    vecs[8] = '{2'b10, O_MUL, 64'd6, 64'd7, 4'hF, 64'd0, 1'b1, 1'b1};
`endif
    opcs = '{O_ADD, O_SUB, O_AND, O_ORR, O_MUL, O_BAD};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; instruction = '0; op_a = '0; op_b = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_code", code, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);

    // Table vectors, one op at a time with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].op, vecs[i].opc, vecs[i].a, vecs[i].b);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_code", i), code, vecs[i].e_code);
      chk($sformatf("vec%0d_result", i), result, vecs[i].e_res);
      chk($sformatf("vec%0d_zero", i), zero, vecs[i].e_zero);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].e_ill);
      tick();
      chk($sformatf("vec%0d_idle", i), out_valid, 0);
    end

    // Back-to-back issue with out_ready held high.
    drive(2'b10, O_ADD, 64'd3, 64'd4);
    tick();
    chk("b2b_add", result, 64'd7);
    chk("b2b_ready0", in_ready, 1);
    drive(2'b10, O_ORR, 64'hF0, 64'h0F);
    tick();
    chk("b2b_orr", result, 64'hFF);
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_ready1", in_ready, 1);
    drive(2'b10, O_AND, 64'hFF, 64'h0F);
    tick();
    chk("b2b_and", result, 64'h0F);
    chk("b2b_ready2", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("b2b_idle", out_valid, 0);

    // Result stall: consumer not ready for 5 cycles, then ready.
    out_ready = 1'b0;
    drive(2'b10, O_SUB, 64'd10, 64'd3);
    tick();
    drive(2'b10, O_ADD, 64'd1, 64'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_result", result, 64'd7);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release_valid", out_valid, 0);
    chk("stall_release_ready", in_ready, 1);

`ifdef ALU_MUL_EN
    begin
      int busy;
      drive(2'b10, O_MUL, 64'h13, 64'h0B);
      tick();
      // Producer keeps requesting another op; it must be ignored while busy.
      drive(2'b10, O_ADD, 64'd1, 64'd2);
      busy = 0;
      while (!out_valid && busy < 200) begin
        chk("mul_in_ready", in_ready, 0);
        busy++;
        tick();
      end
      in_valid = 1'b0;
      chk("mul_busy_cycles", busy, W);
      chk("mul_valid", out_valid, 1);
      chk("mul_result", result, 64'hD1);
      chk("mul_code", code, 4'h8);
      chk("mul_zero", zero, 0);
      tick();
      tick();
      chk("mul_done_idle", out_valid, 0);
    end
    begin
      int seen;
      drive(2'b10, O_MUL, 64'h13, 64'h0B);
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mulrst_in_ready", in_ready, 1);
      chk("mulrst_result", result, 0);
      chk("mulrst_code", code, 0);
      seen = 0;
      for (int k = 0; k < W + 8; k++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("mulrst_never_valid", seen, 0);
    end
`else
    drive(2'b10, O_MUL, 64'h13, 64'h0B);
    tick();
    in_valid = 1'b0;
    chk("nomul_valid", out_valid, 1);
    chk("nomul_code", code, 4'hF);
    chk("nomul_illegal", illegal, 1);
    chk("nomul_result", result, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("donerst_valid", out_valid, 0);
    chk("donerst_code", code, 0);
    chk("donerst_illegal", illegal, 0);
    chk("donerst_zero", zero, 0);
    tick();
`endif

    // Randomized ops against the reference model with random result stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 120; i++) begin
      logic [1:0]   op;
      logic [10:0]  opc;
      logic [W-1:0] a, b;
      exp_t         e;
      int           n, st;
      op  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) op = 2'b10;
      n   = $urandom_range(0, 6);
      opc = (n == 6) ? 11'($urandom) : opcs[n];
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 255));
      e = model(op, opc, a, b);
      drive(op, opc, a, b);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin
        tick();
        n++;
      end
      chk("rnd_valid", out_valid, 1);
      st = $urandom_range(0, 2);
      for (int k = 0; k < st; k++) tick();
      chk("rnd_code", code, e.code);
      chk("rnd_result", result, e.res);
      chk("rnd_zero", zero, (e.res == '0));
      chk("rnd_illegal", illegal, e.ill);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
